tetris_rotate_kick: RTL and testbench

Parametrised rotation engine for the Tetris game FSM, the next-generation replacement for the fixed 10x20, clockwise-only rotate handler. On a `start` pulse it latches the active piece and tests the target orientation against the board occupancy bitmap. It tests one placement candidate per cycle, optionally including wall-kick offsets, and returns the accepted rotation and pivot location with a one-cycle `done` pulse. It sits between the game state machine (ROTATE_PIECE state) and the piece-position registers.

---
 rtl/tetris_rotate_kick.sv | 239 +++++++++++++++++++++++
 tb/tb_tetris_rotate_kick.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tetris_rotate_kick.sv
// Rotation engine for the active piece: tests the target orientation against the board, one
// placement candidate per cycle. Define ROT_KICK_EN to also try the wall-kick candidates 1-3.
module tetris_rotate_kick #(
  parameter int unsigned COLS  = 10,
  parameter int unsigned ROWS  = 20,
  parameter int unsigned LOC_W = $clog2(COLS * ROWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dir,
  input  logic [2:0]             piece_type,
  input  logic [1:0]             rotation,
  input  logic [LOC_W-1:0]       location,
  input  logic [COLS*ROWS-1:0]   blocks_exist,
  output logic                   busy,
  output logic                   done,
  output logic                   ok,
  output logic [1:0]             rot_out,
  output logic [LOC_W-1:0]       loc_out
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned SR_W  = ROW_W + 1;
  localparam int unsigned SC_W  = COL_W + 1;

`ifdef ROT_KICK_EN
  localparam logic [1:0] LastCand = 2'd3;
`else
  localparam logic [1:0] LastCand = 2'd0;
`endif

  localparam logic [2:0] PtSquare = 3'd0;
  localparam logic [2:0] PtBar    = 3'd1;
  localparam logic [2:0] PtS      = 3'd2;
  localparam logic [2:0] PtZ      = 3'd3;
  localparam logic [2:0] PtL      = 3'd4;
  localparam logic [2:0] PtJ      = 3'd5;
  localparam logic [2:0] PtT      = 3'd6;

  typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

  // Packs four (drow, dcol) offsets, cell 0 in the top bits, 3-bit two's complement each.
  function automatic logic [23:0] cells(input int r0, c0, r1, c1, r2, c2, r3, c3);
    return {3'(r0), 3'(c0), 3'(r1), 3'(c1), 3'(r2), 3'(c2), 3'(r3), 3'(c3)};
  endfunction

  function automatic logic [23:0] shape(input logic [2:0] pt, input logic [1:0] r);
    logic [23:0] s;
    s = cells(0, 0, 0, 1, 1, 0, 1, 1);  // SQUARE, also used for unassigned codes
    case (pt)
      PtSquare: s = cells(0, 0, 0, 1, 1, 0, 1, 1);
      PtBar: s = r[0] ? cells(-2, 0, -1, 0, 0, 0, 1, 0) : cells(0, -1, 0, 0, 0, 1, 0, 2);
      PtS:   s = r[0] ? cells(-1, 0, 0, 0, 0, 1, 1, 1) : cells(0, -1, 0, 0, -1, 0, -1, 1);
      PtZ:   s = r[0] ? cells(-1, 1, 0, 1, 0, 0, 1, 0) : cells(-1, -1, -1, 0, 0, 0, 0, 1);
      PtL: begin
        case (r)
          2'd0:    s = cells(0, -1, 0, 0, 0, 1, -1, 1);
          2'd1:    s = cells(-1, 0, 0, 0, 1, 0, 1, 1);
          2'd2:    s = cells(0, -1, 0, 0, 0, 1, 1, -1);
          default: s = cells(-1, -1, -1, 0, 0, 0, 1, 0);
        endcase
      end
      PtJ: begin
        case (r)
          2'd0:    s = cells(-1, -1, 0, -1, 0, 0, 0, 1);
          2'd1:    s = cells(-1, 0, -1, 1, 0, 0, 1, 0);
          2'd2:    s = cells(0, -1, 0, 0, 0, 1, 1, 1);
          default: s = cells(-1, 0, 0, 0, 1, 0, 1, -1);
        endcase
      end
      PtT: begin
        case (r)
          2'd0:    s = cells(0, -1, 0, 0, 0, 1, -1, 0);
          2'd1:    s = cells(-1, 0, 0, 0, 1, 0, 0, 1);
          2'd2:    s = cells(0, -1, 0, 0, 0, 1, 1, 0);
          default: s = cells(-1, 0, 0, 0, 1, 0, 0, -1);
        endcase
      end
      default: s = cells(0, 0, 0, 1, 1, 0, 1, 1);
    endcase
    return s;
  endfunction

  function automatic logic [LOC_W-1:0] to_idx(input logic [ROW_W-1:0] r,
                                              input logic [COL_W-1:0] c);
    return LOC_W'(r) * LOC_W'(COLS) + LOC_W'(c);
  endfunction

  state_e               state_q, state_d;
  logic [1:0]           cand_q, cand_d;
  logic [2:0]           pt_q, pt_d;
  logic [1:0]           rot_q, rot_d;
  logic [1:0]           tr_q, tr_d;
  logic [ROW_W-1:0]     prow_q, prow_d;
  logic [COL_W-1:0]     pcol_q, pcol_d;
  logic [LOC_W-1:0]     loc_q, loc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;
  logic [1:0]           rot_out_q, rot_out_d;
  logic [LOC_W-1:0]     loc_out_q, loc_out_d;

  logic signed [SR_W-1:0] kick_dr, cand_row;
  logic signed [SC_W-1:0] kick_dc, cand_col;
  logic [23:0]            shape_w;
  logic signed [2:0]      cell_dr  [4];
  logic signed [2:0]      cell_dc  [4];
  logic signed [SR_W-1:0] cell_row [4];
  logic signed [SC_W-1:0] cell_col [4];
  logic [LOC_W-1:0]       cell_idx [4];
  logic [3:0]             cell_ok;
  logic                   all_legal;
  logic [LOC_W-1:0]       cand_idx;

  always_comb begin
    kick_dr = '0;
    kick_dc = '0;
    case (cand_q)
      2'd1:    kick_dc = '1;
      2'd2:    kick_dc = SC_W'(1);
      2'd3:    kick_dr = '1;
      default: ;
    endcase
    cand_row = $signed({1'b0, prow_q}) + kick_dr;
    cand_col = $signed({1'b0, pcol_q}) + kick_dc;
    cand_idx = to_idx(cand_row[ROW_W-1:0], cand_col[COL_W-1:0]);
  end

  // Sign bit catches cells left of / above the board before any index is used.
  always_comb begin
    shape_w   = shape(pt_q, tr_q);
    all_legal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cell_dr[i]  = shape_w[23-6*i -: 3];
      cell_dc[i]  = shape_w[20-6*i -: 3];
      cell_row[i] = cand_row + SR_W'(cell_dr[i]);
      cell_col[i] = cand_col + SC_W'(cell_dc[i]);
      cell_idx[i] = to_idx(cell_row[i][ROW_W-1:0], cell_col[i][COL_W-1:0]);
      cell_ok[i]  = !cell_row[i][SR_W-1] && ($unsigned(cell_row[i]) < SR_W'(ROWS)) &&
                    !cell_col[i][SC_W-1] && ($unsigned(cell_col[i]) < SC_W'(COLS)) &&
                    !blocks_exist[cell_idx[i]];
      all_legal   = all_legal & cell_ok[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    pt_d      = pt_q;
    rot_d     = rot_q;
    tr_d      = tr_q;
    prow_d    = prow_q;
    pcol_d    = pcol_q;
    loc_d     = loc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    rot_out_d = rot_out_q;
    loc_out_d = loc_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pt_d    = piece_type;
          rot_d   = rotation;
          tr_d    = dir ? rotation - 2'd1 : rotation + 2'd1;
          prow_d  = ROW_W'(location / LOC_W'(COLS));
          pcol_d  = COL_W'(location % LOC_W'(COLS));
          loc_d   = location;
          cand_d  = '0;
          busy_d  = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (all_legal) begin
          ok_d      = 1'b1;
          rot_out_d = tr_q;
          loc_out_d = cand_idx;
          done_d    = 1'b1;
          state_d   = StDone;
        end else if (cand_q == LastCand) begin
          ok_d      = 1'b0;
          rot_out_d = rot_q;
          loc_out_d = loc_q;
          done_d    = 1'b1;
          state_d   = StDone;
        end else begin
          cand_d = cand_q + 2'd1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cand_q    <= '0;
      pt_q      <= '0;
      rot_q     <= '0;
      tr_q      <= '0;
      prow_q    <= '0;
      pcol_q    <= '0;
      loc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      rot_out_q <= '0;
      loc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      pt_q      <= pt_d;
      rot_q     <= rot_d;
      tr_q      <= tr_d;
      prow_q    <= prow_d;
      pcol_q    <= pcol_d;
      loc_q     <= loc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      rot_out_q <= rot_out_d;
      loc_out_q <= loc_out_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ok      = ok_q;
  assign rot_out = rot_out_q;
  assign loc_out = loc_out_q;

endmodule

// File: tb/tb_tetris_rotate_kick.sv
// Bench for tetris_rotate_kick: directed scenarios plus random requests checked against a
// cell-by-cell placement model. Build with or without ROT_KICK_EN to match the RTL.
`timescale 1ns/1ps
module tb_tetris_rotate_kick;
  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int N     = COLS * ROWS;
  localparam int LOC_W = 8;
`ifdef ROT_KICK_EN
  localparam int NCAND = 4;
  localparam bit KICK  = 1'b1;
`else
  localparam int NCAND = 1;
  localparam bit KICK  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, start, dir;
  logic [2:0]       piece_type;
  logic [1:0]       rotation;
  logic [LOC_W-1:0] location;
  logic [N-1:0]     blocks_exist;
  logic             busy, done, ok;
  logic [1:0]       rot_out;
  logic [LOC_W-1:0] loc_out;

  int tests = 0;
  int fails = 0;

  // Footprints as (drow, dcol) x4, indexed [piece][rotation]; piece codes SQUARE..T = 0..6.
  int shp [7][4][8] = '{
    '{'{0,0,0,1,1,0,1,1},     '{0,0,0,1,1,0,1,1},   '{0,0,0,1,1,0,1,1},    '{0,0,0,1,1,0,1,1}},
    '{'{0,-1,0,0,0,1,0,2},    '{-2,0,-1,0,0,0,1,0}, '{0,-1,0,0,0,1,0,2},   '{-2,0,-1,0,0,0,1,0}},
    '{'{0,-1,0,0,-1,0,-1,1},  '{-1,0,0,0,0,1,1,1},  '{0,-1,0,0,-1,0,-1,1}, '{-1,0,0,0,0,1,1,1}},
    '{'{-1,-1,-1,0,0,0,0,1},  '{-1,1,0,1,0,0,1,0},  '{-1,-1,-1,0,0,0,0,1}, '{-1,1,0,1,0,0,1,0}},
    '{'{0,-1,0,0,0,1,-1,1},   '{-1,0,0,0,1,0,1,1},  '{0,-1,0,0,0,1,1,-1},  '{-1,-1,-1,0,0,0,1,0}},
    '{'{-1,-1,0,-1,0,0,0,1},  '{-1,0,-1,1,0,0,1,0}, '{0,-1,0,0,0,1,1,1},   '{-1,0,0,0,1,0,1,-1}},
    '{'{0,-1,0,0,0,1,-1,0},   '{-1,0,0,0,1,0,0,1},  '{0,-1,0,0,0,1,1,0},   '{-1,0,0,0,1,0,0,-1}}
  };
  int kdr [4] = '{0, 0, 0, -1};
  int kdc [4] = '{0, -1, 1, 0};

  always #5 clk = ~clk;

  tetris_rotate_kick #(.COLS(COLS), .ROWS(ROWS), .LOC_W(LOC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dir          (dir),
    .piece_type   (piece_type),
    .rotation     (rotation),
    .location     (location),
    .blocks_exist (blocks_exist),
    .busy         (busy),
    .done         (done),
    .ok           (ok),
    .rot_out      (rot_out),
    .loc_out      (loc_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input logic d, input int pt, input int r, input int loc,
                                input logic [N-1:0] b, output int eok, output int erot,
                                output int eloc, output int elat);
    int pr, pc, tr, rr, cc;
    bit fits;
    pr   = loc / COLS;
    pc   = loc % COLS;
    tr   = (r + (d ? 3 : 1)) % 4;
    eok  = 0;
    erot = r;
    eloc = loc;
    elat = NCAND + 1;
    for (int c = 0; c < NCAND; c++) begin
      if (eok == 0) begin
        fits = 1'b1;
        for (int i = 0; i < 4; i++) begin
          rr = pr + kdr[c] + shp[pt][tr][2*i];
          cc = pc + kdc[c] + shp[pt][tr][2*i+1];
          if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) fits = 1'b0;
          else if (b[rr*COLS+cc]) fits = 1'b0;
        end
        if (fits) begin
          eok  = 1;
          erot = tr;
          eloc = (pr + kdr[c]) * COLS + pc + kdc[c];
          elat = c + 2;
        end
      end
    end
  endfunction

  // Entered and left at a negedge; latency counts clock edges from the start-sampling edge.
  task automatic req(input string tag, input logic d, input logic [2:0] pt, input logic [1:0] r,
                     input int loc, input logic [N-1:0] b, input bit extra,
                     input int eok, input int erot, input int eloc, input int elat);
    int lat;
    dir = d; piece_type = pt; rotation = r; location = LOC_W'(loc); blocks_exist = b;
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      start = (extra && n <= 2);
      check({tag, ".busy"}, busy, 1);
      if (done) lat = n;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".ok"}, ok, eok);
    check({tag, ".rot_out"}, rot_out, erot);
    check({tag, ".loc_out"}, loc_out, eloc);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".done_fall"}, done, 0);
    check({tag, ".busy_fall"}, busy, 0);
    check({tag, ".ok_hold"}, ok, eok);
    check({tag, ".rot_hold"}, rot_out, erot);
    check({tag, ".loc_hold"}, loc_out, eloc);
  endtask

  initial begin
    logic [N-1:0] empty_b, full_b, rb;
    int eok, erot, eloc, elat, loc, pt;
    empty_b = '0;
    full_b  = '1;
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; piece_type = '0; rotation = '0;
    location = '0; blocks_exist = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.ok", ok, 0);
    check("rst.rot", rot_out, 0);
    check("rst.loc", loc_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    req("s1", 1'b0, 3'd1, 2'd0, 105, empty_b, 1'b0, 1, 1, 105, 2);
    if (KICK) req("s2", 1'b1, 3'd1, 2'd1, 100, empty_b, 1'b0, 1, 0, 101, 4);
    else      req("s2", 1'b1, 3'd1, 2'd1, 100, empty_b, 1'b0, 0, 1, 100, 2);
    req("s3", 1'b0, 3'd6, 2'd2, 55, full_b, 1'b0, 0, 2, 55, KICK ? 5 : 2);
    req("s4", 1'b1, 3'd0, 2'd0, 55, empty_b, 1'b0, 1, 3, 55, 2);

    // Extra starts while busy must be dropped, then back-to-back requests.
    req("s5a", 1'b0, 3'd1, 2'd0, 105, empty_b, 1'b1, 1, 1, 105, 2);
    @(negedge clk);
    check("s5.no_second_done", done, 0);
    req("s5b", 1'b0, 3'd1, 2'd0, 105, empty_b, 1'b0, 1, 1, 105, 2);
    req("s5c", 1'b1, 3'd0, 2'd0, 55, empty_b, 1'b0, 1, 3, 55, 2);

    // Reset while the scenario-2 request is in CHECK.
    dir = 1'b1; piece_type = 3'd1; rotation = 2'd1; location = LOC_W'(100);
    blocks_exist = empty_b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("s6.busy", busy, 0);
    check("s6.done", done, 0);
    check("s6.ok", ok, 0);
    check("s6.rot", rot_out, 0);
    check("s6.loc", loc_out, 0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (n == 1) rst_n = 1'b1;
      check("s6.no_done", done, 0);
    end
    req("s6b", 1'b0, 3'd1, 2'd0, 105, empty_b, 1'b0, 1, 1, 105, 2);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++) rb[i] = ($urandom_range(0, 3) == 0);
      if (t % 4 == 0) rb = '0;
      pt = int'($urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       loc = int'($urandom_range(0, ROWS - 1)) * COLS;
          1:       loc = int'($urandom_range(0, ROWS - 1)) * COLS + COLS - 1;
          2:       loc = int'($urandom_range(0, COLS - 1));
          default: loc = (ROWS - 1) * COLS + int'($urandom_range(0, COLS - 1));
        endcase
      end else begin
        loc = int'($urandom_range(0, N - 1));
      end
      dir = 1'($urandom_range(0, 1));
      rotation = 2'($urandom_range(0, 3));
      model(dir, pt, int'(rotation), loc, rb, eok, erot, eloc, elat);
      req("rnd", dir, 3'(pt), rotation, loc, rb, 1'b0, eok, erot, eloc, elat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
